// File: rtl/dmem_arb_pkg.sv
// Shared encodings and defaults for the data-memory arbiter and its read-return helper.
// Used by dmem_arbiter (which also honours the optional DMEM_ARB_RR_EN build macro).
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DBG  = 2'd2,
      ST_LOCK = 2'd3
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   localparam int STARVE_MAX_DEFAULT = 4;
   localparam int STARVE_CNT_W       = 4;

   // Saturating increment of the debug wait counter.
   function automatic logic [STARVE_CNT_W-1:0] starve_inc(
      input logic [STARVE_CNT_W-1:0] cnt,
      input logic [STARVE_CNT_W-1:0] lim
   );
      return (cnt >= lim) ? lim : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_rd_return.sv
// Registered read-return for one requester: captures memory data on a granted load
// and raises a one-cycle valid pulse on the following cycle.
module dmem_rd_return
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_stb,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;

   // Stage p1: one cycle after the granted load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= ld_stb;
         if (ld_stb) begin
            data_p1 <= mem_rdata;
         end
      end
   end

   assign rvalid = vld_p1;
   assign rdata  = data_p1;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU load/store port and the debug/loader port.
// Build macro DMEM_ARB_RR_EN selects round-robin conflict resolution instead of fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              dbg_lock,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       cpu_win;
   logic       dbg_win;
   logic       lock_hold;
   logic       conflict;
   logic       dbg_pick;

`ifdef DMEM_ARB_RR_EN
   logic last_win;

   // On a conflict the port that did not win most recently goes first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_win <= PORT_DBG;
      end else if (cpu_win) begin
         last_win <= PORT_CPU;
      end else if (dbg_win) begin
         last_win <= PORT_DBG;
      end
   end

   assign dbg_pick = (last_win == PORT_CPU);
`else
   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] starve_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (dbg_req && !dbg_win) begin
         starve_cnt <= starve_inc(starve_cnt, STARVE_LIM);
      end else begin
         starve_cnt <= '0;
      end
   end

   // A debug request denied STARVE_MAX cycles in a row is forced through once.
   assign dbg_pick = (starve_cnt == STARVE_LIM);
`endif

   assign conflict = cpu_req && dbg_req;

   // Arbitration: a held lock excludes the CPU; a released lock arbitrates normally this cycle.
   always_comb begin
      cpu_win   = 1'b0;
      dbg_win   = 1'b0;
      lock_hold = reset && (state == ST_LOCK) && dbg_lock;
      if (reset) begin
         if (lock_hold) begin
            dbg_win = dbg_req;
         end else if (conflict) begin
            dbg_win = dbg_pick;
            cpu_win = !dbg_pick;
         end else begin
            cpu_win = cpu_req;
            dbg_win = dbg_req;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_IDLE;
      if (lock_hold) begin
         state_nxt = ST_LOCK;
      end else if (cpu_win) begin
         state_nxt = ST_CPU;
      end else if (dbg_win) begin
         state_nxt = dbg_lock ? ST_LOCK : ST_DBG;
      end
   end

   always_comb begin
      cpu_gnt   = cpu_win;
      dbg_gnt   = dbg_win;
      cpu_stall = reset && cpu_req && !cpu_win;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_win) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_win) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   assign owner = state;

   dmem_rd_return #(
      .DATA_W(DATA_W)
   ) u_cpu_ret (
      .clk      (clk),
      .reset    (reset),
      .ld_stb   (cpu_win && !cpu_we),
      .mem_rdata(mem_rdata),
      .rvalid   (cpu_rvalid),
      .rdata    (cpu_rdata)
   );

   dmem_rd_return #(
      .DATA_W(DATA_W)
   ) u_dbg_ret (
      .clk      (clk),
      .reset    (reset),
      .ld_stb   (dbg_win && !dbg_we),
      .mem_rdata(mem_rdata),
      .rvalid   (dbg_rvalid),
      .rdata    (dbg_rdata)
   );

   a_one_grant : assert property (@(posedge clk) disable iff (!reset) !(cpu_gnt && dbg_gnt));

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store port and a debug/loader port.
- The debug/loader port is used for program/data preload, memory inspection and burst dumps.
- Sits between the core datapath and the data memory; the memory has a combinational read and a write on the clock edge.
- Adds request/grant handshaking, a CPU stall indication, registered read-return, a debug lock (burst) mode and starvation protection.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied cycles after which a waiting debug request is forced through (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_req  in  1  CPU access request; held with stable fields until cpu_gnt.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_gnt  out  1  access performed this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  one-cycle pulse, read data valid.
- cpu_rdata  out  DATA_W  registered load data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same meanings for the debug port.
- dbg_lock  in  1  debug requests exclusive ownership while high.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.
- owner  out  2  current FSM state, debug visibility.

Behaviour:
- FSM states: IDLE=0, CPU=1, DBG=2, LOCK=3. State reflects the port that won the previous cycle.
- Arbitration is evaluated every cycle, combinationally from req, state and starve_cnt. At most one gnt per cycle. A transaction is one cycle long.
- Fixed priority: CPU wins if cpu_req, unless starve_cnt == STARVE_MAX and dbg_req, in which case debug wins.
- Transitions:
  - IDLE/CPU/DBG → CPU on a CPU win.
  - → DBG on a debug win with dbg_lock=0.
  - → LOCK on a debug win with dbg_lock=1.
  - → IDLE when there is no request.
  - LOCK: only debug can be granted; the CPU is stalled. LOCK → IDLE when dbg_lock=0, evaluated that same cycle (normal arbitration applies).
- starve_cnt (4 bits):
  - Increments when dbg_req=1 and dbg_gnt=0, saturating at STARVE_MAX.
  - Clears on dbg_gnt or when dbg_req=0.
- Memory mux:
  - mem_addr and mem_wdata come from the winning port.
  - mem_we = winner_we & gnt.
  - With no winner, mem_addr/mem_wdata = 0 and mem_we = 0.
- Read return:
  - On a granted load, mem_rdata is registered into x_rdata.
  - x_rvalid pulses for exactly 1 cycle on the following cycle; latency from gnt to rvalid is 1.
  - Stores produce no rvalid.
  - x_rdata holds its value until the next load on that port.
- Simultaneous requests: debug waits unless forced; a forced grant serves debug for one cycle, then priority reverts.
- Reset (async, any time):
  - state=IDLE, starve_cnt=0.
  - All gnt, rvalid and mem_we = 0; rdata = 0.
  - An in-flight rvalid is discarded.
  - Outputs are valid again on the first edge after deassertion.
- dbg_lock with dbg_req=0 in LOCK: ownership is held, no grants, cpu_stall stays high.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined:
  - Round-robin replaces fixed priority. On a CPU/debug conflict, the port not granted most recently wins.
  - A one-bit last-winner flag resets to debug, so the CPU wins the first conflict.
  - starve_cnt logic is removed and STARVE_MAX is ignored.
  - LOCK behaviour is unchanged.
- Undefined: fixed priority with starvation forcing, as described above.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - State encodings ST_IDLE, ST_CPU, ST_DBG, ST_LOCK (2-bit).
  - Port-id constants PORT_CPU=0, PORT_DBG=1.
  - Default STARVE_MAX.
- One sub-module: dmem_rd_return, instantiated once per port. It holds the registered rdata/rvalid given a granted-load strobe and mem_rdata.

Test Plan:
- Single CPU load, addr 0x10, memory holds 0xDEADBEEF → cpu_gnt in the same cycle, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in the next cycle, mem_we=0.
- Debug store of 0x12345678 to 0x20, then CPU load from 0x20 → mem_we=1 for exactly 1 cycle; the CPU load returns 0x12345678.
- CPU and debug both request continuously, STARVE_MAX=4, fixed priority → CPU granted on 4 cycles, debug granted on the 5th, pattern repeats; cpu_stall=1 only on the debug cycles.
- With DMEM_ARB_RR_EN, both requesting continuously → grants alternate CPU, debug, CPU, debug starting with CPU.
- dbg_lock=1 with 3 debug stores while cpu_req=1 → owner=3, cpu_stall=1 throughout; after dbg_lock falls, the CPU is granted in that cycle.
- Reset pulsed low during the cycle after a CPU load grant → cpu_rvalid stays 0, owner=0, all outputs 0 until the post-reset request.
